ring_osc_freq_meter: RTL and testbench

Multi-channel frequency meter for on-die ring oscillators. It selects one of CHANNELS asynchronous oscillator outputs and synchronises it into clk. It counts rising edges over a programmable gate window of clk cycles and presents a saturating count with a valid/ack handshake. It replaces free-running per-oscillator ripple counters with a deterministic, clk-domain measurement.

---
 rtl/ring_osc_freq_meter.sv | 180 ++++++++++++++++++
 tb/tb_ring_osc_freq_meter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// Gated rising-edge counter for CHANNELS asynchronous ring oscillators.
// Define RING_OSC_FM_CONT_EN for free-running back-to-back windows.
module ring_osc_freq_meter #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 12,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] osc_in,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic [GATE_W-1:0]   gate_cycles,
    input  logic                start,
    output logic                busy,
    output logic [CNT_W-1:0]    result,
    output logic [SEL_W-1:0]    result_ch,
    output logic                result_valid,
    input  logic                result_ack,
    output logic                overflow
);
    localparam int SET_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_e;

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0] prev_q, prev_d, rise;
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d, res_ch_q, res_ch_d, sel_in;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d, gate_m1;
    logic [CNT_W-1:0]  cnt_q, cnt_d, res_q, res_d, cnt_up, fin_cnt;
    logic ovf_q, ovf_d, res_ovf_q, res_ovf_d, valid_q, valid_d;
    logic pulse, ovf_up, fin, fin_ovf, launch;

    always_comb begin
        sync_d = '0;
        prev_d = '0;
        rise   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], osc_in[i]};
            prev_d[i] = sync_q[i][SYNC_STAGES-1];
            rise[i]   = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
        end
    end

    assign pulse  = rise[sel_q];
    assign sel_in = (32'(ch_sel) < CHANNELS) ? ch_sel : '0;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gate_d    = gate_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ch_d  = res_ch_q;
        res_ovf_d = res_ovf_q;
        valid_d   = valid_q;
        launch    = 1'b0;
        fin       = 1'b0;
        // saturating increment: hold at all-ones and flag the lost edge
        cnt_up    = (pulse && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        ovf_up    = ovf_q | (pulse & (&cnt_q));
        fin_cnt   = cnt_up;
        fin_ovf   = ovf_up;
        gate_m1   = TMR_W'(gate_q) - 1'b1;
        unique case (state_q)
            IDLE: launch = start;
            SETTLE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (gate_q == '0) begin
                    fin     = 1'b1;
                    fin_cnt = '0;
                    fin_ovf = 1'b0;
                end else begin
                    state_d = MEASURE;
                    tmr_d   = gate_m1;
                end
            end
            MEASURE: begin
                cnt_d = cnt_up;
                ovf_d = ovf_up;
                if (tmr_q == '0) begin
                    fin = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: begin
`ifdef RING_OSC_FM_CONT_EN
                // DONE doubles as the first cycle of the next window
                valid_d = 1'b0;
                if (!start) begin
                    state_d = IDLE;
                end else if (gate_q == '0) begin
                    fin     = 1'b1;
                    fin_cnt = '0;
                    fin_ovf = 1'b0;
                end else begin
                    cnt_d = cnt_up;
                    ovf_d = ovf_up;
                    if (tmr_q == '0) begin
                        fin = 1'b1;
                    end else begin
                        state_d = MEASURE;
                        tmr_d   = tmr_q - 1'b1;
                    end
                end
`else
                if (result_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    launch  = start;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = SETTLE;
            sel_d   = sel_in;
            gate_d  = gate_cycles;
            tmr_d   = TMR_W'(SYNC_STAGES);
            cnt_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end
        if (fin) begin
            state_d   = DONE;
            res_d     = fin_cnt;
            res_ovf_d = fin_ovf;
            res_ch_d  = sel_q;
            valid_d   = 1'b1;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            tmr_d     = gate_m1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= '0;
            state_q   <= IDLE;
            sel_q     <= '0;
            gate_q    <= '0;
            tmr_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ch_q  <= '0;
            res_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            gate_q    <= gate_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ch_q  <= res_ch_d;
            res_ovf_q <= res_ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result       = res_q;
    assign result_ch    = res_ch_q;
    assign result_valid = valid_q;
    assign overflow     = res_ovf_q;
endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Randomised bench for ring_osc_freq_meter: expected counts come from
// oscillator period arithmetic (floor/ceil of window length / period).
`timescale 1ns/1ps
module tb_ring_osc_freq_meter;
    localparam int SS     = 2;
    localparam int CNT_W  = 8;
    localparam int GATE_W = 12;
    localparam int MAXC   = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        osc;
    logic [1:0]        ch_sel = '0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic              start = 1'b0;
    logic              result_ack = 1'b0;
    logic              busy, result_valid, overflow;
    logic [CNT_W-1:0]  result;
    logic [1:0]        result_ch;
    logic              busy3, valid3, overflow3;
    logic [CNT_W-1:0]  result3;
    logic [1:0]        result_ch3;
    int osc_half [4] = '{0, 0, 0, 0};
    int checks = 0;
    int errors = 0;

    ring_osc_freq_meter #(
        .CHANNELS(4), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst(rst), .osc_in(osc), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .start(start), .busy(busy),
        .result(result), .result_ch(result_ch),
        .result_valid(result_valid), .result_ack(result_ack),
        .overflow(overflow)
    );

    ring_osc_freq_meter #(
        .CHANNELS(3), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)
    ) dut3 (
        .clk(clk), .rst(rst), .osc_in(osc[2:0]), .ch_sel(ch_sel),
        .gate_cycles(gate_cycles), .start(start), .busy(busy3),
        .result(result3), .result_ch(result_ch3),
        .result_valid(valid3), .result_ack(result_ack),
        .overflow(overflow3)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_osc
        logic o = 1'b0;
        assign osc[g] = o;
        initial begin
            #1.3;
            forever begin
                if (osc_half[g] == 0) begin
                    o = 1'b0;
                    #1;
                end else begin
                    #(osc_half[g]) o = ~o;
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: sim time exceeded, errors so far %0d", errors);
        $fatal(1);
    end

    function automatic int exp_lo(int gate, int half);
        int v;
        if (half == 0) return 0;
        v = (gate * 10) / (2 * half);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic int exp_hi(int gate, int half);
        int v;
        if (half == 0) return 0;
        v = (gate * 10 + 2 * half - 1) / (2 * half);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic set_osc(input int h0, input int h1, input int h2,
                           input int h3);
        osc_half[0] = h0;
        osc_half[1] = h1;
        osc_half[2] = h2;
        osc_half[3] = h3;
        repeat (6) @(negedge clk);
    endtask

    task automatic launch(input logic [1:0] ch, input int gate,
                          input bit ack_too, input bit noise,
                          output int lat);
        ch_sel      = ch;
        gate_cycles = GATE_W'(gate);
        start       = 1'b1;
        result_ack  = ack_too;
        @(negedge clk);
        start      = 1'b0;
        result_ack = 1'b0;
        lat        = -1;
        for (int n = 1; n <= gate + SS + 40; n++) begin
            if (result_valid) begin
                lat = n - 1;
                break;
            end
            if (noise) begin
                start      = 1'($urandom);
                result_ack = 1'($urandom);
                ch_sel     = 2'($urandom);
            end
            @(negedge clk);
        end
        start      = 1'b0;
        result_ack = 1'b0;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b valid=%b expected 0 0",
                     busy, result_valid);
        end
        checks++;
        if (result !== '0 || result_ch !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: result=%0d ch=%0d ovf=%b expected 0",
                     result, result_ch, overflow);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b expected 0 0",
                     busy, result_valid);
        end
    endtask

`ifdef RING_OSC_FM_CONT_EN
    task automatic test_cont();
        int n;
        set_osc(13, 50, 17, 0);
        ch_sel      = 2'd1;
        gate_cycles = GATE_W'(200);
        start       = 1'b1;
        @(negedge clk);
        n = 1;
        while (!result_valid && n < 260) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n - 1 !== SS + 1 + 200) begin
            errors++;
            $display("FAIL cont_first_latency: got %0d expected %0d",
                     n - 1, SS + 1 + 200);
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (int'(result) < exp_lo(200, 50) ||
                int'(result) > exp_hi(200, 50) || result_ch !== 2'd1) begin
                errors++;
                $display("FAIL cont_result%0d: got %0d ch %0d expected %0d..%0d ch 1",
                         p, result, result_ch, exp_lo(200, 50), exp_hi(200, 50));
            end
            if (p == 3) break;
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0) begin
                errors++;
                $display("FAIL cont_pulse_width%0d: valid=%b expected 0",
                         p, result_valid);
            end
            if (p == 2) start = 1'b0;
            n = 1;
            while (!result_valid && n < 260) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 200) begin
                errors++;
                $display("FAIL cont_interval%0d: got %0d expected 200", p, n);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_busy_last: got %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: busy=%b valid=%b expected 0 0",
                     busy, result_valid);
        end
    endtask
`else
    task automatic test_basic();
        int lat;
        set_osc(13, 40, 17, 0);
        launch(2'd1, 800, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== SS + 1 + 800) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, SS + 801);
        end
        checks++;
        if (int'(result) < exp_lo(800, 40) || int'(result) > exp_hi(800, 40)) begin
            errors++;
            $display("FAIL basic_result: got %0d expected %0d..%0d",
                     result, exp_lo(800, 40), exp_hi(800, 40));
        end
        checks++;
        if (result_ch !== 2'd1 || overflow !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_flags: ch=%0d ovf=%b busy=%b expected 1 0 1",
                     result_ch, overflow, busy);
        end
        do_ack();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: busy=%b valid=%b expected 0 0",
                     busy, result_valid);
        end
    endtask

    task automatic test_saturate();
        int lat;
        int held;
        set_osc(20, 40, 17, 0);
        launch(2'd0, 2000, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== SS + 1 + 2000) begin
            errors++;
            $display("FAIL sat_latency: got %0d expected %0d", lat, SS + 2001);
        end
        checks++;
        if (result !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_result: got %0d ovf %b expected 255 ovf 1",
                     result, overflow);
        end
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1 && result === 8'd255) held++;
        end
        checks++;
        if (held !== 20) begin
            errors++;
            $display("FAIL sat_hold: valid held %0d cycles expected 20", held);
        end
        do_ack();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_ack: busy=%b valid=%b expected 0 0",
                     busy, result_valid);
        end
        checks++;
        if (result !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_keep: got %0d ovf %b expected 255 ovf 1",
                     result, overflow);
        end
    endtask

    task automatic test_gate_zero();
        int lat;
        launch(2'd0, 0, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== SS + 1) begin
            errors++;
            $display("FAIL gate0_latency: got %0d expected %0d", lat, SS + 1);
        end
        checks++;
        if (result !== '0 || overflow !== 1'b0 || result_ch !== 2'd0) begin
            errors++;
            $display("FAIL gate0_result: got %0d ovf %b ch %0d expected 0 0 0",
                     result, overflow, result_ch);
        end
        do_ack();
    endtask

    task automatic test_isolation();
        int lat;
        set_osc(0, 0, 15, 0);
        launch(2'd3, 500, 1'b0, 1'b0, lat);
        checks++;
        if (result !== '0 || result_ch !== 2'd3) begin
            errors++;
            $display("FAIL iso_static: got %0d ch %0d expected 0 ch 3",
                     result, result_ch);
        end
        checks++;
        if (result_ch3 !== 2'd0 || result3 !== '0) begin
            errors++;
            $display("FAIL iso_oor_ch: got ch %0d res %0d expected ch 0 res 0",
                     result_ch3, result3);
        end
        do_ack();
        launch(2'd2, 500, 1'b0, 1'b0, lat);
        checks++;
        if (int'(result) < exp_lo(500, 15) || int'(result) > exp_hi(500, 15)) begin
            errors++;
            $display("FAIL iso_active: got %0d expected %0d..%0d",
                     result, exp_lo(500, 15), exp_hi(500, 15));
        end
        do_ack();
        set_osc(25, 0, 15, 0);
        launch(2'd3, 400, 1'b0, 1'b0, lat);
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL iso_ch3_quiet: got %0d expected 0", result);
        end
        checks++;
        if (int'(result3) < exp_lo(400, 25) || int'(result3) > exp_hi(400, 25) ||
            result_ch3 !== 2'd0) begin
            errors++;
            $display("FAIL iso_oor_count: got %0d ch %0d expected %0d..%0d ch 0",
                     result3, result_ch3, exp_lo(400, 25), exp_hi(400, 25));
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        set_osc(12, 20, 30, 40);
        launch(2'd0, 300, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== SS + 301 ||
            int'(result) < exp_lo(300, 12) || int'(result) > exp_hi(300, 12)) begin
            errors++;
            $display("FAIL b2b_first: lat %0d res %0d expected %0d res %0d..%0d",
                     lat, result, SS + 301, exp_lo(300, 12), exp_hi(300, 12));
        end
        launch(2'd3, 250, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== SS + 251) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected %0d", lat, SS + 251);
        end
        checks++;
        if (int'(result) < exp_lo(250, 40) || int'(result) > exp_hi(250, 40) ||
            result_ch !== 2'd3) begin
            errors++;
            $display("FAIL b2b_result: got %0d ch %0d expected %0d..%0d ch 3",
                     result, result_ch, exp_lo(250, 40), exp_hi(250, 40));
        end
        do_ack();
    endtask

    task automatic test_random();
        int lat, ch, gate, gmax;
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 4; c++) begin
                osc_half[c] = ($urandom_range(0, 4) == 0) ? 0 :
                              int'($urandom_range(12, 40));
            end
            repeat (6) @(negedge clk);
            ch   = int'($urandom_range(0, 3));
            gmax = (osc_half[ch] == 0) ? 700 : (254 * 2 * osc_half[ch]) / 10 - 1;
            if (gmax > 700) gmax = 700;
            gate = int'($urandom_range(0, gmax));
            launch(2'(ch), gate, 1'b0, 1'b1, lat);
            checks++;
            if (lat !== SS + 1 + gate) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d expected %0d",
                         it, lat, SS + 1 + gate);
            end
            checks++;
            if (int'(result) < exp_lo(gate, osc_half[ch]) ||
                int'(result) > exp_hi(gate, osc_half[ch])) begin
                errors++;
                $display("FAIL rand%0d_result: got %0d expected %0d..%0d",
                         it, result, exp_lo(gate, osc_half[ch]),
                         exp_hi(gate, osc_half[ch]));
            end
            checks++;
            if (int'(result_ch) !== ch || overflow !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_ch: got ch %0d ovf %b expected ch %0d ovf 0",
                         it, result_ch, overflow, ch);
            end
            do_ack();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_osc(13, 25, 17, 30);
        ch_sel      = 2'd2;
        gate_cycles = GATE_W'(1000);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0 ||
            result_ch !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: busy=%b valid=%b res=%0d ch=%0d ovf=%b expected all 0",
                     busy, result_valid, result, result_ch, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        launch(2'd1, 100, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== SS + 101 ||
            int'(result) < exp_lo(100, 25) || int'(result) > exp_hi(100, 25) ||
            result_ch !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_fresh: lat %0d res %0d ch %0d expected %0d %0d..%0d 1",
                     lat, result, result_ch, SS + 101,
                     exp_lo(100, 25), exp_hi(100, 25));
        end
        do_ack();
    endtask
`endif

    initial begin
        test_reset();
`ifdef RING_OSC_FM_CONT_EN
        test_cont();
`else
        test_basic();
        test_saturate();
        test_gate_zero();
        test_isolation();
        test_back_to_back();
        test_random();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
